seq_restoring_div: RTL and testbench

//   Multi-cycle radix-2 restoring unsigned integer divider for the PE datapath.
//   It is the inverse companion to the multiply-add chain: where the adder tree

---
 rtl/pe_div_pkg.sv | 14 +
 rtl/seq_restoring_div_if.sv | 25 ++
 rtl/seq_restoring_div_ripple_sub.sv | 23 ++
 rtl/seq_restoring_div.sv | 116 +++++++++++
 tb/tb_seq_restoring_div.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pe_div_pkg.sv
// Shared definitions for the PE datapath divider: FSM state encoding and the
// fill bit used to build the divide-by-zero quotient.
package pe_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A zero divisor returns a quotient with this bit replicated across the word.
    localparam logic DBZ_QUOT_FILL = 1'b1;

endpackage

// File: rtl/seq_restoring_div_if.sv
// Operand/result handshake bundle for seq_restoring_div.
// The master side supplies operands and takes results; the slave is the divider.
interface seq_restoring_div_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_div_ripple_sub.sv
// N-bit ripple-borrow subtractor (diff = a - b) built from full-subtractor cells;
// borrow is the borrow out of the top cell, i.e. set when a < b.
module ripple_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N:0] borrow_chain;

    assign borrow_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fs
            assign diff[gi]           = a[gi] ^ b[gi] ^ borrow_chain[gi];
            assign borrow_chain[gi+1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow_chain[gi]);
        end
    endgenerate

    assign borrow = borrow_chain[N];
endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle radix-2 restoring unsigned divider: one quotient bit per cycle,
// valid/ready handshakes on both sides, all outputs registered.
module seq_restoring_div
    import pe_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_restoring_div_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dq_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dq_next;
    logic             unused_trial_msb;

    // dq holds the not-yet-consumed dividend bits on the left and the
    // quotient bits retired so far on the right.
    assign shifted = {rem_reg, dq_reg[WIDTH-1]};

    ripple_sub #(.N(WIDTH + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, divisor_reg}),
        .diff   (trial),
        .borrow (borrow)
    );

    // rem < divisor always holds, so a successful trial never sets the top bit.
    assign unused_trial_msb = trial[WIDTH];
    assign rem_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign dq_next  = {dq_reg[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            dq_reg        <= '0;
            divisor_reg   <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_reg <= 1'b0;
                        divisor_reg  <= bus.divisor;
                        if (bus.divisor == '0) begin
                            quotient_reg  <= {WIDTH{DBZ_QUOT_FILL}};
                            remainder_reg <= bus.dividend;
                            dbz_reg       <= 1'b1;
                            out_valid_reg <= 1'b1;
                            state_reg     <= S_DONE;
                        end else begin
                            rem_reg   <= '0;
                            dq_reg    <= bus.dividend;
                            cnt_reg   <= CNT_W'(WIDTH - 1);
                            state_reg <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_reg <= rem_next;
                    dq_reg  <= dq_next;
                    if (cnt_reg == '0) begin
                        quotient_reg  <= dq_next;
                        remainder_reg <= rem_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        quotient_reg  <= '0;
                        remainder_reg <= '0;
                        dbz_reg       <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed bench for seq_restoring_div (WIDTH=16): latency, results, hold,
// mid-operation reset and a back-to-back run against a q=a/b, r=a%b model.
module tb_seq_restoring_div;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    seq_restoring_div_if #(.WIDTH(W)) bus ();

    seq_restoring_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a negedge, then measure latency and check results.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int elat, input int hold,
                          input string tag);
        int lat;
        int w;
        logic [W-1:0] q0, r0;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            if (lat == 2) begin
                check({tag, "_run_in_ready"}, bus.in_ready, 0);
                check({tag, "_run_quotient"}, bus.quotient, 0);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, elat);
        check({tag, "_quotient"}, bus.quotient, eq);
        check({tag, "_remainder"}, bus.remainder, er);
        check({tag, "_dbz"}, bus.div_by_zero, edbz);
        q0 = bus.quotient;
        r0 = bus.remainder;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, bus.out_valid, 1);
            check({tag, "_hold_in_ready"}, bus.in_ready, 0);
            check({tag, "_hold_q"}, bus.quotient, q0);
            check({tag, "_hold_r"}, bus.remainder, r0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_idle_valid"}, bus.out_valid, 0);
        check({tag, "_idle_in_ready"}, bus.in_ready, 1);
        check({tag, "_idle_quotient"}, bus.quotient, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int issued, got, cyc, last_acc;
        logic [W-1:0] a, b, ea, eb;
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_quotient", bus.quotient, 0);
        check("reset_remainder", bus.remainder, 0);
        check("reset_dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, W + 1, 0, "div_100_7");
        run_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, W + 1, 0, "div_ffff_1");
        run_op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, W + 1, 0, "div_3_10");
        run_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, W + 1, 0, "div_ffff_ffff");
        run_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, 0, "div_5_0");
        run_op(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, W + 1, 10, "hold_50_5");
        run_op(16'd77, 16'd8, 16'd9, 16'd5, 1'b0, W + 1, 0, "after_hold");

        // Reset pulse in the middle of RUN.
        bus.in_valid = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("midrun_busy", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", bus.in_ready, 1);
        check("midrun_rst_out_valid", bus.out_valid, 0);
        check("midrun_rst_quotient", bus.quotient, 0);
        check("midrun_rst_remainder", bus.remainder, 0);
        check("midrun_rst_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, W + 1, 0, "div_1000_3");

        // Back-to-back: in_valid and out_ready held high.
        issued = 0;
        got = 0;
        cyc = 0;
        last_acc = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        while (got < 200 && cyc < 20000) begin
            if (issued == 200) bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                if (qa.size() == 0) begin
                    check("b2b_spurious_valid", bus.out_valid, 0);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    check("b2b_quotient", bus.quotient, ea / eb);
                    check("b2b_remainder", bus.remainder, ea % eb);
                    check("b2b_dbz", bus.div_by_zero, 0);
                end
                got++;
            end
            if (bus.in_ready && issued < 200) begin
                a = W'($urandom_range(0, 65535));
                b = W'($urandom_range(1, (issued % 3 == 0) ? 15 : 65535));
                bus.dividend = a;
                bus.divisor  = b;
                qa.push_back(a);
                qb.push_back(b);
                if (issued > 0) check("b2b_period", cyc - last_acc, W + 2);
                last_acc = cyc;
                issued++;
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b_result_count", got, 200);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
